// File: rtl/lea_pkg.sv
// Shared definitions for the LEA round-key XOR datapath: word width, block
// mode encodings and the mapping of key words onto data words.
package lea_pkg;

    localparam int LEA_WORD_W = 32;

    localparam logic MODE_PLAIN = 1'b0;
    localparam logic MODE_FOLD  = 1'b1;

    // Index of the data word that key word k is XORed into. A return value of
    // num_words means the key word does not contribute to the output.
    function automatic int fold_target(input logic mode, input int k, input int num_words);
        if (k < num_words) begin
            return k;
        end else if (mode == MODE_FOLD) begin
            return num_words - 1;
        end else begin
            return num_words;
        end
    endfunction

endpackage

// File: rtl/lea_xor_core.sv
// Combinational XOR of one data block with a round key; in FOLD mode the
// surplus key words are all folded into the top data word.
module lea_xor_core
    import lea_pkg::*;
#(
    parameter int WORD_W    = LEA_WORD_W,
    parameter int NUM_WORDS = 4,
    parameter int KEY_WORDS = 6
) (
    input  logic [NUM_WORDS*WORD_W-1:0] din,
    input  logic [KEY_WORDS*WORD_W-1:0] rk,
    input  logic                        mode,
    output logic [NUM_WORDS*WORD_W-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] acc;

            always_comb begin
                acc = din[gi*WORD_W +: WORD_W];
                for (int k = 0; k < KEY_WORDS; k++) begin
                    if (fold_target(mode, k, NUM_WORDS) == gi) begin
                        acc = acc ^ rk[k*WORD_W +: WORD_W];
                    end
                end
            end

            assign dout[gi*WORD_W +: WORD_W] = acc;
        end
    endgenerate

endmodule

// File: rtl/lea_key_xor_pipe.sv
// Pipelined LEA round-key XOR stage: held key register, one output register
// backed by a skid register, registered InReady and a transfer counter.
module lea_key_xor_pipe
    import lea_pkg::*;
#(
    parameter int WORD_W    = LEA_WORD_W,
    parameter int NUM_WORDS = 4,
    parameter int KEY_WORDS = 6,
    parameter int CNT_W     = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        KeyLoad,
    input  logic [KEY_WORDS*WORD_W-1:0] KeyIn,
    output logic                        KeyValid,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic                        InMode,
    input  logic [NUM_WORDS*WORD_W-1:0] Din,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [NUM_WORDS*WORD_W-1:0] Dout,
    output logic                        OutMode,
    output logic [CNT_W-1:0]            BlockCount
);

    localparam int DW = NUM_WORDS * WORD_W;
    localparam int KW = KEY_WORDS * WORD_W;

    logic [KW-1:0]    key_reg,        key_next;
    logic             key_valid_reg,  key_valid_next;
    logic             in_ready_reg,   in_ready_next;
    logic [DW-1:0]    oreg_data_reg,  oreg_data_next;
    logic             oreg_mode_reg,  oreg_mode_next;
    logic             oreg_valid_reg, oreg_valid_next;
    logic [DW-1:0]    sreg_data_reg,  sreg_data_next;
    logic             sreg_mode_reg,  sreg_mode_next;
    logic             sreg_valid_reg, sreg_valid_next;
    logic [CNT_W-1:0] count_reg,      count_next;

    logic [DW-1:0]    xor_result;
    logic             accept;
    logic             drain;

    // The key register output feeds the core, so a block accepted in the
    // KeyLoad cycle is processed with the key that was already held.
    lea_xor_core #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .KEY_WORDS (KEY_WORDS)
    ) u_core (
        .din  (Din),
        .rk   (key_reg),
        .mode (InMode),
        .dout (xor_result)
    );

    assign accept = InValid & in_ready_reg;
    assign drain  = oreg_valid_reg & OutReady;

    always_comb begin
        key_next        = key_reg;
        key_valid_next  = key_valid_reg;
        oreg_data_next  = oreg_data_reg;
        oreg_mode_next  = oreg_mode_reg;
        oreg_valid_next = oreg_valid_reg;
        sreg_data_next  = sreg_data_reg;
        sreg_mode_next  = sreg_mode_reg;
        sreg_valid_next = sreg_valid_reg;
        count_next      = count_reg;

        if (KeyLoad) begin
            key_next       = KeyIn;
            key_valid_next = 1'b1;
        end

        if (drain) begin
            count_next = count_reg + CNT_W'(1);
        end

        // InReady is low while the skid holds a block, so accept cannot
        // coincide with an occupied skid register.
        if (sreg_valid_reg) begin
            if (OutReady) begin
                oreg_data_next  = sreg_data_reg;
                oreg_mode_next  = sreg_mode_reg;
                sreg_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!oreg_valid_reg || OutReady) begin
                oreg_data_next  = xor_result;
                oreg_mode_next  = InMode;
                oreg_valid_next = 1'b1;
            end else begin
                sreg_data_next  = xor_result;
                sreg_mode_next  = InMode;
                sreg_valid_next = 1'b1;
            end
        end else if (drain) begin
            oreg_valid_next = 1'b0;
        end

        in_ready_next = key_valid_next & ~sreg_valid_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_reg        <= '0;
            key_valid_reg  <= 1'b0;
            in_ready_reg   <= 1'b0;
            oreg_data_reg  <= '0;
            oreg_mode_reg  <= 1'b0;
            oreg_valid_reg <= 1'b0;
            sreg_data_reg  <= '0;
            sreg_mode_reg  <= 1'b0;
            sreg_valid_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            key_reg        <= key_next;
            key_valid_reg  <= key_valid_next;
            in_ready_reg   <= in_ready_next;
            oreg_data_reg  <= oreg_data_next;
            oreg_mode_reg  <= oreg_mode_next;
            oreg_valid_reg <= oreg_valid_next;
            sreg_data_reg  <= sreg_data_next;
            sreg_mode_reg  <= sreg_mode_next;
            sreg_valid_reg <= sreg_valid_next;
            count_reg      <= count_next;
        end
    end

    assign KeyValid   = key_valid_reg;
    assign InReady    = in_ready_reg;
    assign OutValid   = oreg_valid_reg;
    assign Dout       = oreg_data_reg;
    assign OutMode    = oreg_mode_reg;
    assign BlockCount = count_reg;

endmodule

// File: tb/tb_lea_key_xor_pipe.sv
// Directed self-checking bench for lea_key_xor_pipe (default widths, 4-bit counter).
module tb_lea_key_xor_pipe;

    logic         CLK = 1'b0;
    logic         RST;
    logic         KeyLoad;
    logic [191:0] KeyIn;
    logic         KeyValid;
    logic         InValid;
    logic         InReady;
    logic         InMode;
    logic [127:0] Din;
    logic         OutValid;
    logic         OutReady;
    logic [127:0] Dout;
    logic         OutMode;
    logic [3:0]   BlockCount;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_cnt  = '0;

    localparam logic [191:0] KEY1 = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

    lea_key_xor_pipe #(
        .WORD_W    (32),
        .NUM_WORDS (4),
        .KEY_WORDS (6),
        .CNT_W     (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .KeyLoad    (KeyLoad),
        .KeyIn      (KeyIn),
        .KeyValid   (KeyValid),
        .InValid    (InValid),
        .InReady    (InReady),
        .InMode     (InMode),
        .Din        (Din),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Dout       (Dout),
        .OutMode    (OutMode),
        .BlockCount (BlockCount)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference for the default 4-word / 6-key mapping.
    function automatic logic [127:0] exp_xor(input logic [127:0] d, input logic [191:0] k,
                                             input logic m);
        logic [127:0] r;
        r = d ^ k[127:0];
        if (m) r[127:96] = r[127:96] ^ k[159:128] ^ k[191:160];
        return r;
    endfunction

    task automatic test_reset();
        RST = 1'b1; KeyLoad = 1'b0; KeyIn = '0; InValid = 1'b1; InMode = 1'b0;
        Din = 128'h1234; OutReady = 1'b1;
        step(); step();
        RST = 1'b0; exp_cnt = '0;
        step(); step();
        n_checks++;
        if (InReady !== 1'b0) begin n_fail++; $display("FAIL reset_inready: got %b want 0", InReady); end
        n_checks++;
        if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
        n_checks++;
        if (BlockCount !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", BlockCount); end
        n_checks++;
        if (Dout !== 128'd0 || OutMode !== 1'b0 || KeyValid !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: Dout=%h OutMode=%b KeyValid=%b want 0/0/0", Dout, OutMode, KeyValid);
        end
        InValid = 1'b0; KeyLoad = 1'b1; KeyIn = KEY1;
        step();
        KeyLoad = 1'b0;
        n_checks++;
        if (KeyValid !== 1'b1 || InReady !== 1'b1) begin
            n_fail++; $display("FAIL key_gate: KeyValid=%b InReady=%b want 1/1", KeyValid, InReady);
        end
        $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_fold();
        InValid = 1'b1; InMode = 1'b1; Din = '0; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        n_checks++;
        if (OutValid !== 1'b1 || Dout !== {32'd7, 32'd3, 32'd2, 32'd1} || OutMode !== 1'b1) begin
            n_fail++; $display("FAIL fold: valid=%b Dout=%h mode=%b want 1/%h/1", OutValid, Dout, OutMode,
                               {32'd7, 32'd3, 32'd2, 32'd1});
        end
        step(); exp_cnt++;
        n_checks++;
        if (OutValid !== 1'b0 || BlockCount !== exp_cnt) begin
            n_fail++; $display("FAIL fold_drain: valid=%b count=%0d want 0/%0d", OutValid, BlockCount, exp_cnt);
        end
        $display("test_fold done: Dout=%h", Dout);
    endtask

    task automatic test_plain();
        InValid = 1'b1; InMode = 1'b0; Din = {4{32'hFFFF_FFFF}};
        step();
        InValid = 1'b0;
        n_checks++;
        if (Dout !== {32'hFFFF_FFFB, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE} || OutMode !== 1'b0) begin
            n_fail++; $display("FAIL plain: Dout=%h mode=%b want fffffffbfffffffcfffffffdfffffffe/0", Dout, OutMode);
        end
        step(); exp_cnt++;
        n_checks++;
        if (BlockCount !== exp_cnt) begin n_fail++; $display("FAIL plain_count: got %0d want %0d", BlockCount, exp_cnt); end
        $display("test_plain done: Dout=%h", Dout);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        OutReady = 1'b1; InValid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            d = {32'hA000_0000 + b, 32'h0B00_0000 + b, 32'h00C0_0000 + b, 32'h000D_0000 + b};
            Din = d; InMode = b[0];
            step();
            if (b > 0) exp_cnt++;
            n_checks++;
            if (OutValid !== 1'b1 || InReady !== 1'b1 || Dout !== exp_xor(d, KEY1, b[0])) begin
                n_fail++; $display("FAIL b2b_%0d: valid=%b ready=%b Dout=%h want 1/1/%h", b, OutValid, InReady, Dout,
                                   exp_xor(d, KEY1, b[0]));
            end
        end
        InValid = 1'b0;
        step(); exp_cnt++;
        n_checks++;
        if (BlockCount !== exp_cnt) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", BlockCount, exp_cnt); end
        $display("test_back_to_back done: count=%0d", BlockCount);
    endtask

    task automatic test_backpressure();
        logic [127:0] blk [4];
        for (int b = 0; b < 4; b++) blk[b] = {4{32'h1111_0000 + 32'(b)}};
        InMode = 1'b0; OutReady = 1'b0; InValid = 1'b1; Din = blk[0];
        step();
        n_checks++;
        if (OutValid !== 1'b1 || InReady !== 1'b1 || Dout !== exp_xor(blk[0], KEY1, 1'b0)) begin
            n_fail++; $display("FAIL bp_first: valid=%b ready=%b Dout=%h", OutValid, InReady, Dout);
        end
        Din = blk[1];
        step();
        n_checks++;
        if (InReady !== 1'b0 || Dout !== exp_xor(blk[0], KEY1, 1'b0)) begin
            n_fail++; $display("FAIL bp_skid: ready=%b Dout=%h want 0/%h", InReady, Dout, exp_xor(blk[0], KEY1, 1'b0));
        end
        Din = blk[2];
        step();
        n_checks++;
        if (InReady !== 1'b0 || OutValid !== 1'b1 || Dout !== exp_xor(blk[0], KEY1, 1'b0)) begin
            n_fail++; $display("FAIL bp_hold: ready=%b valid=%b Dout=%h", InReady, OutValid, Dout);
        end
        OutReady = 1'b1;
        step(); exp_cnt++;
        n_checks++;
        if (InReady !== 1'b1 || Dout !== exp_xor(blk[1], KEY1, 1'b0)) begin
            n_fail++; $display("FAIL bp_release: ready=%b Dout=%h want 1/%h", InReady, Dout, exp_xor(blk[1], KEY1, 1'b0));
        end
        step(); exp_cnt++;
        Din = blk[3];
        n_checks++;
        if (OutValid !== 1'b1 || Dout !== exp_xor(blk[2], KEY1, 1'b0)) begin
            n_fail++; $display("FAIL bp_blk3: valid=%b Dout=%h want %h", OutValid, Dout, exp_xor(blk[2], KEY1, 1'b0));
        end
        step(); exp_cnt++;
        InValid = 1'b0;
        n_checks++;
        if (OutValid !== 1'b1 || Dout !== exp_xor(blk[3], KEY1, 1'b0)) begin
            n_fail++; $display("FAIL bp_blk4: valid=%b Dout=%h want %h", OutValid, Dout, exp_xor(blk[3], KEY1, 1'b0));
        end
        step(); exp_cnt++;
        n_checks++;
        if (OutValid !== 1'b0 || BlockCount !== exp_cnt) begin
            n_fail++; $display("FAIL bp_end: valid=%b count=%0d want 0/%0d", OutValid, BlockCount, exp_cnt);
        end
        $display("test_backpressure done: count=%0d", BlockCount);
    endtask

    task automatic test_key_race();
        logic [127:0] da, db;
        da = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h5555_AAAA};
        db = {32'hCAFE_F00D, 32'h7654_3210, 32'hFEDC_BA98, 32'h0F0F_F0F0};
        OutReady = 1'b1; InMode = 1'b1; InValid = 1'b1; Din = da;
        KeyLoad = 1'b1; KeyIn = '0;
        step();
        KeyLoad = 1'b0; Din = db;
        n_checks++;
        if (Dout !== exp_xor(da, KEY1, 1'b1)) begin
            n_fail++; $display("FAIL race_old_key: Dout=%h want %h", Dout, exp_xor(da, KEY1, 1'b1));
        end
        step(); exp_cnt++;
        InValid = 1'b0;
        n_checks++;
        if (Dout !== db) begin n_fail++; $display("FAIL race_new_key: Dout=%h want %h", Dout, db); end
        step(); exp_cnt++;
        n_checks++;
        if (BlockCount !== exp_cnt) begin n_fail++; $display("FAIL race_count: got %0d want %0d", BlockCount, exp_cnt); end
        $display("test_key_race done: count=%0d", BlockCount);
    endtask

    task automatic test_counter_wrap();
        RST = 1'b1; InValid = 1'b0; KeyLoad = 1'b0; OutReady = 1'b1;
        step();
        RST = 1'b0; exp_cnt = '0;
        KeyLoad = 1'b1; KeyIn = KEY1;
        step();
        KeyLoad = 1'b0; InValid = 1'b1; InMode = 1'b0;
        for (int b = 0; b < 17; b++) begin
            Din = 128'(b);
            step();
        end
        InValid = 1'b0;
        n_checks++;
        if (BlockCount !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d want 0", BlockCount); end
        step();
        n_checks++;
        if (BlockCount !== 4'd1 || OutValid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_17: count=%0d valid=%b want 1/0", BlockCount, OutValid);
        end
        $display("test_counter_wrap done: count=%0d", BlockCount);
    endtask

    task automatic test_reset_full();
        OutReady = 1'b0; InValid = 1'b1; InMode = 1'b1; Din = 128'hFACE;
        step(); step();
        n_checks++;
        if (InReady !== 1'b0 || OutValid !== 1'b1) begin
            n_fail++; $display("FAIL full_before_reset: ready=%b valid=%b want 0/1", InReady, OutValid);
        end
        RST = 1'b1;
        step();
        RST = 1'b0; OutReady = 1'b1;
        n_checks++;
        if (OutValid !== 1'b0 || KeyValid !== 1'b0 || InReady !== 1'b0 || BlockCount !== 4'd0 || Dout !== 128'd0) begin
            n_fail++; $display("FAIL reset_full: valid=%b keyvalid=%b ready=%b count=%0d Dout=%h want all 0",
                               OutValid, KeyValid, InReady, BlockCount, Dout);
        end
        step(); step();
        n_checks++;
        if (InReady !== 1'b0 || OutValid !== 1'b0) begin
            n_fail++; $display("FAIL key_lost: ready=%b valid=%b want 0/0", InReady, OutValid);
        end
        InValid = 1'b0;
        $display("test_reset_full done");
    endtask

    initial begin
        test_reset();
        test_fold();
        test_plain();
        test_back_to_back();
        test_backpressure();
        test_key_race();
        test_counter_wrap();
        test_reset_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
